ide_pio_host: RTL and testbench
===============================

Name: ide_pio_host

Overview:
- Host-side ATA PIO initiator. Turns single-word register/data requests from the local bus into correctly timed _CS/DA/_DIOR/_DIOW cycles on the IDE connector.
- It is the active counterpart of the passive swap adapter: it originates the strobes that the adapter and drive respond to.
- Handles IORDY stretching with a timeout.
- Optionally applies the same data-register byte-swap rule, including the Identify exemption, on the host side.

Parameters:
- T_SETUP, 3: CLK cycles from address/_CS valid to strobe assert; range 1..255.
- T_ACTIVE, 8: minimum strobe-low cycles; range 1..255.
- T_HOLD, 2: cycles from strobe deassert to address/_CS/write-data release; range 1..255.
- T_RECOVER, 6: idle cycles with _CS=11 before the next cycle may start; range 1..255.
- WAIT_MAX, 1000: maximum IORDY-stretch cycles before timeout; range 1..65535.

Ports:
- CLK  in  1  system clock.
- _RESET  in  1  asynchronous active-low reset.
- REQ  in  1  request, sampled in IDLE.
- WR  in  1  1=write, 0=read.
- CS_SEL  in  2  _CS value for this cycle, active-low pattern: 10=task file, 01=control.
- ADDR  in  3  DA value.
- WDATA  in  16  write data.
- ACK  out  1  one-cycle accept pulse.
- BUSY  out  1  high from accept until DONE.
- DONE  out  1  one-cycle completion pulse.
- RDATA  out  16  read data; valid from DONE, held until the next read completes.
- TIMEOUT  out  1  set with DONE if IORDY wait expired; cleared at next accept.
- _CS  out  2  IDE chip selects.
- DA  out  3  IDE address.
- _DIOR  out  1  read strobe.
- _DIOW  out  1  write strobe.
- DD  inout  16  IDE data bus.
- IORDY  in  1  drive ready, asynchronous.

Behaviour:
- Clocking: one clock (CLK). Reset is asynchronous and active-low (_RESET).
- Reset values: ACK=0, BUSY=0, DONE=0, RDATA=0, TIMEOUT=0, _CS=11, DA=000, _DIOR=1, _DIOW=1, DD hi-Z, state IDLE, counters 0.
- Mid-cycle reset: strobes return high immediately and no DONE is issued.
- All pin outputs are registered, with no combinational path from REQ to the pins.
- State machine: IDLE -> SETUP -> ACTIVE -> HOLD -> RECOVER -> IDLE.
- IDLE:
  - On an edge with REQ=1, capture WR, CS_SEL, ADDR and WDATA.
  - Drive _CS=CS_SEL and DA=ADDR, pulse ACK, set BUSY, clear TIMEOUT, enter SETUP.
  - REQ held high during BUSY is ignored.
- SETUP: lasts T_SETUP cycles. On writes, DD drives the (swapped) write data from SETUP entry.
- ACTIVE:
  - _DIOR or _DIOW is low; the strobe asserts on the SETUP->ACTIVE edge.
  - Lasts T_ACTIVE cycles. On its final cycle, if the 2-flop-synchronised IORDY is 0, ACTIVE extends and the wait counter increments.
  - Exit when synced IORDY=1, or when the wait counter reaches WAIT_MAX; the latter sets TIMEOUT.
- ACTIVE->HOLD edge: the strobe deasserts. On reads, DD (swapped if applicable) is registered into an internal read register on this same edge.
- HOLD: lasts T_HOLD cycles, keeping _CS/DA and write data. On exit, _CS=11, DA=000 and DD goes hi-Z.
- RECOVER: lasts T_RECOVER cycles, then IDLE.
- Completion:
  - DONE=1 for the first IDLE cycle; RDATA updates on that same edge for reads; BUSY falls on that same edge.
  - A REQ accepted in that cycle starts back-to-back.
- Latency with no stretch: DONE rises T_SETUP+T_ACTIVE+T_HOLD+T_RECOVER cycles after ACK rises (19 with defaults).
- Bus ownership: DD is never driven during reads or in IDLE/RECOVER. _DIOR and _DIOW are never low simultaneously.
- Counters:
  - Phase counter is 8-bit, reloaded on each state entry.
  - Wait counter is 16-bit, saturates, and is cleared on ACTIVE entry.

Optional Feature:
- Macro: IDE_SWAP_EN.
- Defined:
  - A write with CS_SEL=10, ADDR=7 latches WDATA[7:0] as last_cmd; reset value 8'h00.
  - Data-register accesses (CS_SEL=10, ADDR=0) swap bytes ({D[7:0],D[15:8]}) in both directions unless last_cmd==8'hEC.
  - All other registers are never swapped.
- Undefined: no last_cmd register and no swapping; data passes straight through.

Decomposition:
- Package ide_pkg holds:
  - state enum (IDLE, SETUP, ACTIVE, HOLD, RECOVER);
  - CS_TASKFILE=2'b10, CS_CONTROL=2'b01, CS_NONE=2'b11;
  - DA_DATA=3'd0, DA_COMMAND=3'd7;
  - CMD_IDENTIFY=8'hEC.
- One sub-module, ide_sync2: 2-flop synchroniser for IORDY, async active-low reset, reset value 1.

Test Plan:
- Write CS_SEL=10, ADDR=7, WDATA=0x00EC with defaults, IORDY=1 -> _DIOW low exactly 8 cycles; _CS/DA valid 3 cycles before and 2 after; DD=0x00EC throughout; DONE 19 cycles after ACK.
- Read data reg, drive supplies DD=0x1234:
  - IDE_SWAP_EN with last_cmd=0x20 -> RDATA=0x3412;
  - after writing 0xEC -> RDATA=0x1234;
  - without macro -> 0x1234 in both cases.
- IORDY held low 20 cycles from ACTIVE start -> _DIOR low extends accordingly; DONE with TIMEOUT=0; RDATA captured after IORDY rise.
- IORDY stuck low, WAIT_MAX=10 -> strobe releases after T_ACTIVE+10 cycles; DONE with TIMEOUT=1; next request clears TIMEOUT.
- REQ held high continuously -> back-to-back cycles; ACK once per cycle; _CS=11 for exactly 6 cycles between; strobes never overlap.
- _RESET asserted mid-ACTIVE of a write -> _DIOW=1, _CS=11, DD hi-Z within the same cycle; no DONE; BUSY=0.

Source files
------------

// File: rtl/ide_pkg.sv
// ide_pkg: shared types and constants for the IDE PIO host.
//   state_e      - PIO cycle sequencer states
//   CS_*         - active-low chip-select patterns
//   DA_*         - task-file register addresses
//   CMD_IDENTIFY - command code that suppresses the data-register byte swap
//   bswap()      - 16-bit byte swap helper
package ide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HOLD,
        RECOVER
    } state_e;

    localparam logic [1:0] CS_TASKFILE  = 2'b10;
    localparam logic [1:0] CS_CONTROL   = 2'b01;
    localparam logic [1:0] CS_NONE      = 2'b11;

    localparam logic [2:0] DA_DATA      = 3'd0;
    localparam logic [2:0] DA_COMMAND   = 3'd7;

    localparam logic [7:0] CMD_IDENTIFY = 8'hEC;

    function automatic logic [15:0] bswap(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/ide_sync2.sv
// ide_sync2: two-flop synchroniser for the asynchronous IORDY pin.
//   clk_i  - system clock
//   rst_ni - asynchronous active-low reset (output resets to 1 = ready)
//   d_i    - asynchronous input
//   q_o    - synchronised output
module ide_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ide_pio_host.sv
// ide_pio_host: host-side ATA PIO initiator. Converts single-word local-bus
// requests into timed _CS/DA/_DIOR/_DIOW cycles with IORDY stretch/timeout.
//   Local bus : CLK, _RESET, REQ, WR, CS_SEL[1:0], ADDR[2:0], WDATA[15:0]
//               ACK, BUSY, DONE, RDATA[15:0], TIMEOUT
//   IDE pins  : _CS[1:0], DA[2:0], _DIOR, _DIOW, DD[15:0] (inout), IORDY
// Build option: define IDE_SWAP_EN to byte-swap data-register accesses
// unless the last command written was IDENTIFY (8'hEC).
module ide_pio_host
    import ide_pkg::*;
#(
    parameter int unsigned T_SETUP   = 3,
    parameter int unsigned T_ACTIVE  = 8,
    parameter int unsigned T_HOLD    = 2,
    parameter int unsigned T_RECOVER = 6,
    parameter int unsigned WAIT_MAX  = 1000
) (
    input  logic        CLK,
    input  logic        _RESET,
    input  logic        REQ,
    input  logic        WR,
    input  logic [1:0]  CS_SEL,
    input  logic [2:0]  ADDR,
    input  logic [15:0] WDATA,
    output logic        ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RDATA,
    output logic        TIMEOUT,
    output logic [1:0]  _CS,
    output logic [2:0]  DA,
    output logic        _DIOR,
    output logic        _DIOW,
    inout  wire  [15:0] DD,
    input  logic        IORDY
);

    // Phase counter reload values: a state lasts (load + 1) cycles.
    localparam logic [7:0]  SETUP_LD = 8'(T_SETUP - 1);
    localparam logic [7:0]  ACT_LD   = 8'(T_ACTIVE - 1);
    localparam logic [7:0]  HOLD_LD  = 8'(T_HOLD - 1);
    localparam logic [7:0]  REC_LD   = 8'(T_RECOVER - 1);
    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] wait_q;
    logic        wr_q, swap_q, to_q;
    logic        ack_q, busy_q, done_q, timeout_q;
    logic [15:0] rd_q, rdata_q;
    logic [1:0]  cs_q;
    logic [2:0]  da_q;
    logic        dior_q, diow_q;
    logic        dd_oe_q;
    logic [15:0] dd_out_q;
    logic        iordy_s;
    logic        take;
    logic        swap_now;

    ide_sync2 u_sync (
        .clk_i  (CLK),
        .rst_ni (_RESET),
        .d_i    (IORDY),
        .q_o    (iordy_s)
    );

`ifdef IDE_SWAP_EN
    logic [7:0] last_cmd_q;
    assign swap_now = (CS_SEL == CS_TASKFILE) && (ADDR == DA_DATA) &&
                      (last_cmd_q != CMD_IDENTIFY);
`else
    assign swap_now = 1'b0;
`endif

    // The last RECOVER cycle doubles as the first IDLE sampling point, so a
    // held REQ restarts with exactly T_RECOVER cycles of _CS=11 in between.
    always_comb begin
        take = 1'b0;
        if (REQ) begin
            if (state_q == IDLE)
                take = 1'b1;
            else if (state_q == RECOVER && cnt_q == '0)
                take = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            wr_q      <= 1'b0;
            swap_q    <= 1'b0;
            to_q      <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rd_q      <= '0;
            rdata_q   <= '0;
            cs_q      <= CS_NONE;
            da_q      <= '0;
            dior_q    <= 1'b1;
            diow_q    <= 1'b1;
            dd_oe_q   <= 1'b0;
            dd_out_q  <= '0;
`ifdef IDE_SWAP_EN
            last_cmd_q <= '0;
`endif
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ACTIVE;
                        cnt_q   <= ACT_LD;
                        wait_q  <= '0;
                        if (wr_q) diow_q <= 1'b0;
                        else      dior_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (iordy_s || wait_q >= WAIT_LIM) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        to_q    <= !iordy_s;
                        dior_q  <= 1'b1;
                        diow_q  <= 1'b1;
                        if (!wr_q) rd_q <= swap_q ? bswap(DD) : DD;
                    end else if (wait_q != '1) begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= RECOVER;
                        cnt_q   <= REC_LD;
                        cs_q    <= CS_NONE;
                        da_q    <= '0;
                        dd_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= to_q;
                        if (!wr_q) rdata_q <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Accept overrides the completion updates above; TIMEOUT of a
            // cycle finishing on the same edge is still reported with DONE.
            if (take) begin
                state_q  <= SETUP;
                cnt_q    <= SETUP_LD;
                ack_q    <= 1'b1;
                busy_q   <= 1'b1;
                to_q     <= 1'b0;
                wr_q     <= WR;
                swap_q   <= swap_now;
                cs_q     <= CS_SEL;
                da_q     <= ADDR;
                dd_oe_q  <= WR;
                dd_out_q <= swap_now ? bswap(WDATA) : WDATA;
                if (state_q == IDLE) timeout_q <= 1'b0;
`ifdef IDE_SWAP_EN
                if (WR && CS_SEL == CS_TASKFILE && ADDR == DA_COMMAND)
                    last_cmd_q <= WDATA[7:0];
`endif
            end
        end
    end

    assign ACK     = ack_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RDATA   = rdata_q;
    assign TIMEOUT = timeout_q;
    assign _CS     = cs_q;
    assign DA      = da_q;
    assign _DIOR   = dior_q;
    assign _DIOW   = diow_q;
    assign DD      = dd_oe_q ? dd_out_q : 16'hzzzz;

endmodule

// File: tb/tb_ide_pio_host.sv
// tb_ide_pio_host: self-checking bench for ide_pio_host. Instance 0 uses the
// default timing, instance 1 uses WAIT_MAX=10 for the IORDY timeout case.
// Expectations follow IDE_SWAP_EN when the bench is built with it.
module tb_ide_pio_host;

`ifdef IDE_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        rst_n = 1'b1;
    logic        WR = 1'b0;
    logic [1:0]  CS_SEL = 2'b11;
    logic [2:0]  ADDR = 3'd0;
    logic [15:0] WDATA = 16'h0000;
    logic [1:0]  req_w = 2'b00;
    logic [1:0]  iordy_w = 2'b11;
    logic [1:0]  ack_w, busy_w, done_w, tmo_w, dior_w, diow_w;
    logic [1:0][1:0]  cs_w;
    logic [1:0][2:0]  da_w;
    logic [1:0][15:0] rdata_w;
    wire  [15:0] dd0, dd1;
    logic [15:0] dev_dd = 16'h0000;
    logic        park = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    // Device model: drives DD while the read strobe is low; "park" drives 0
    // so an unexpected DUT driver becomes visible.
    assign dd0 = !dior_w[0] ? dev_dd : (park ? 16'h0000 : 16'hzzzz);
    assign dd1 = !dior_w[1] ? dev_dd : (park ? 16'h0000 : 16'hzzzz);

    always #5 CLK = ~CLK;

    ide_pio_host #(.T_SETUP(3), .T_ACTIVE(8), .T_HOLD(2), .T_RECOVER(6), .WAIT_MAX(1000)) u_dut (
        .CLK(CLK), ._RESET(rst_n), .REQ(req_w[0]), .WR(WR), .CS_SEL(CS_SEL), .ADDR(ADDR),
        .WDATA(WDATA), .ACK(ack_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .RDATA(rdata_w[0]),
        .TIMEOUT(tmo_w[0]), ._CS(cs_w[0]), .DA(da_w[0]), ._DIOR(dior_w[0]), ._DIOW(diow_w[0]),
        .DD(dd0), .IORDY(iordy_w[0])
    );

    ide_pio_host #(.WAIT_MAX(10)) u_dut_to (
        .CLK(CLK), ._RESET(rst_n), .REQ(req_w[1]), .WR(WR), .CS_SEL(CS_SEL), .ADDR(ADDR),
        .WDATA(WDATA), .ACK(ack_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .RDATA(rdata_w[1]),
        .TIMEOUT(tmo_w[1]), ._CS(cs_w[1]), .DA(da_w[1]), ._DIOR(dior_w[1]), ._DIOW(diow_w[1]),
        .DD(dd1), .IORDY(iordy_w[1])
    );

    typedef struct {
        logic        wr;
        logic [1:0]  cs;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] dev;
        logic [15:0] exp;   // expected DD for writes, expected RDATA for reads
    } vec_t;

    typedef struct packed {
        int          ack_n, ack_i, done_i, low, pre, post, overlap, wrong, dd_bad;
        logic [15:0] rdata;
        logic        tmo, tmo_at_ack, busy_at_ack, busy_at_done;
        logic [1:0]  cs_at;
        logic [2:0]  da_at;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One PIO transaction on instance u. For writes d1 is the DD value expected
    // on the bus; for reads it is what the device drives. A nonzero stretch
    // pulls IORDY low at the first strobe-low sample and releases it "stretch"
    // samples later, switching the device data to d2.
    task automatic run_txn(input int u, input logic wr, input logic [1:0] cs, input logic [2:0] addr,
                           input logic [15:0] wdata, input logic [15:0] d1, input int stretch,
                           input logic [15:0] d2, output res_t r);
        logic strobe, other;
        logic [15:0] dd;
        int st_i;
        r = '0;
        st_i = -1;
        @(negedge CLK);
        WR = wr; CS_SEL = cs; ADDR = addr; WDATA = wdata; dev_dd = d1;
        req_w[u] = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            dd = (u == 0) ? dd0 : dd1;
            if (ack_w[u]) begin
                r.ack_n++;
                if (r.ack_n == 1) begin
                    r.ack_i = i; r.tmo_at_ack = tmo_w[u]; r.busy_at_ack = busy_w[u];
                end
                req_w[u] = 1'b0;
            end
            strobe = wr ? diow_w[u] : dior_w[u];
            other  = wr ? dior_w[u] : diow_w[u];
            if (!dior_w[u] && !diow_w[u]) r.overlap++;
            if (!other) r.wrong++;
            if (!strobe) begin
                if (r.low == 0) begin
                    r.cs_at = cs_w[u]; r.da_at = da_w[u];
                    if (stretch > 0) begin iordy_w[u] = 1'b0; st_i = i; end
                end
                r.low++;
            end
            if (cs_w[u] != 2'b11) begin
                if (r.low == 0) r.pre++;
                else if (strobe) r.post++;
                if (wr && dd !== d1) r.dd_bad++;
            end
            if (st_i >= 0 && i == st_i + stretch) begin iordy_w[u] = 1'b1; dev_dd = d2; end
            if (done_w[u]) begin
                r.done_i = i; r.rdata = rdata_w[u]; r.tmo = tmo_w[u]; r.busy_at_done = busy_w[u];
                break;
            end
        end
        req_w[u] = 1'b0;
    endtask

    vec_t vt [8];
    res_t r;
    logic [15:0] last_rd;

    initial begin
        vt[0] = '{1'b1, 2'b10, 3'd7, 16'h0020, 16'h0000, 16'h0020};
        vt[1] = '{1'b0, 2'b10, 3'd0, 16'h0000, 16'h1234, SWAP ? 16'h3412 : 16'h1234};
        vt[2] = '{1'b1, 2'b10, 3'd0, 16'hBEEF, 16'h0000, SWAP ? 16'hEFBE : 16'hBEEF};
        vt[3] = '{1'b0, 2'b01, 3'd6, 16'h0000, 16'h00A5, 16'h00A5};
        vt[4] = '{1'b1, 2'b10, 3'd7, 16'h00EC, 16'h0000, 16'h00EC};
        vt[5] = '{1'b0, 2'b10, 3'd0, 16'h0000, 16'h1234, 16'h1234};
        vt[6] = '{1'b1, 2'b10, 3'd0, 16'hBEEF, 16'h0000, 16'hBEEF};
        vt[7] = '{1'b0, 2'b10, 3'd1, 16'h0000, 16'hCAFE, 16'hCAFE};

        // Reset state, both instances, during and after reset.
        park = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_pins%0d", u),
                  {ack_w[u], busy_w[u], done_w[u], tmo_w[u], cs_w[u], da_w[u], dior_w[u], diow_w[u]},
                  11'b00001100011);
            check($sformatf("rst_rdata%0d", u), rdata_w[u], 16'h0000);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_pins0", {ack_w[0], busy_w[0], done_w[0], cs_w[0], dior_w[0], diow_w[0]}, 7'b0001111);
        check("idle_dd0_free", dd0, 16'h0000);
        check("idle_dd1_free", dd1, 16'h0000);
        park = 1'b0;

        // Table-driven single transactions with default timing.
        last_rd = 16'h0000;
        for (int v = 0; v < 8; v++) begin
            run_txn(0, vt[v].wr, vt[v].cs, vt[v].addr, vt[v].wdata,
                    vt[v].wr ? vt[v].exp : vt[v].dev, 0, 16'h0000, r);
            if (!vt[v].wr) last_rd = vt[v].exp;
            check($sformatf("v%0d_ack_count", v), r.ack_n, 1);
            check($sformatf("v%0d_ack_cycle", v), r.ack_i, 1);
            check($sformatf("v%0d_busy_at_ack", v), r.busy_at_ack, 1);
            check($sformatf("v%0d_latency", v), r.done_i - r.ack_i, 19);
            check($sformatf("v%0d_strobe_low", v), r.low, 8);
            check($sformatf("v%0d_setup", v), r.pre, 3);
            check($sformatf("v%0d_hold", v), r.post, 2);
            check($sformatf("v%0d_overlap", v), r.overlap + r.wrong, 0);
            check($sformatf("v%0d_cs", v), r.cs_at, vt[v].cs);
            check($sformatf("v%0d_da", v), r.da_at, vt[v].addr);
            check($sformatf("v%0d_busy_at_done", v), r.busy_at_done, 0);
            check($sformatf("v%0d_timeout", v), r.tmo, 0);
            check($sformatf("v%0d_rdata", v), r.rdata, last_rd);
            if (vt[v].wr) check($sformatf("v%0d_dd_bad", v), r.dd_bad, 0);
        end

        // IORDY low for 20 cycles from ACTIVE start: 8 + 15 extra strobe-low
        // cycles (2-flop sync delay), data sampled after the IORDY rise.
        run_txn(0, 1'b0, 2'b01, 3'd6, 16'h0000, 16'hAAAA, 20, 16'h5678, r);
        check("str_strobe_low", r.low, 23);
        check("str_latency", r.done_i - r.ack_i, 34);
        check("str_timeout", r.tmo, 0);
        check("str_rdata", r.rdata, 16'h5678);
        check("str_overlap", r.overlap + r.wrong, 0);

        // IORDY stuck low on the WAIT_MAX=10 instance.
        run_txn(1, 1'b0, 2'b01, 3'd6, 16'h0000, 16'h1111, 100000, 16'h0000, r);
        check("to_strobe_low", r.low, 18);
        check("to_latency", r.done_i - r.ack_i, 29);
        check("to_timeout", r.tmo, 1);
        iordy_w[1] = 1'b1;
        repeat (4) @(negedge CLK);
        check("to_timeout_held", tmo_w[1], 1);
        run_txn(1, 1'b1, 2'b01, 3'd6, 16'h0004, 16'h0004, 0, 16'h0000, r);
        check("to_clear_at_ack", r.tmo_at_ack, 0);
        check("to_next_low", r.low, 8);
        check("to_next_timeout", r.tmo, 0);

        // REQ held high: back-to-back writes.
        begin
            int acks, dones, both, gaps, gap_bad, run, ovl, a0, a1;
            acks = 0; dones = 0; both = 0; gaps = 0; gap_bad = 0; run = 0; ovl = 0; a0 = 0; a1 = 0;
            @(negedge CLK);
            WR = 1'b1; CS_SEL = 2'b10; ADDR = 3'd1; WDATA = 16'h1111;
            req_w[0] = 1'b1;
            for (int i = 1; i <= 70; i++) begin
                @(negedge CLK);
                if (!dior_w[0] && !diow_w[0]) ovl++;
                if (done_w[0]) dones++;
                if (ack_w[0] && done_w[0]) both++;
                if (ack_w[0]) begin
                    acks++;
                    if (acks == 1) a0 = i;
                    if (acks == 2) a1 = i;
                    if (acks == 3) req_w[0] = 1'b0;
                end
                if (cs_w[0] == 2'b11) begin
                    if (acks > 0) run++;
                end else begin
                    if (run > 0) begin
                        gaps++;
                        if (run != 6) gap_bad++;
                    end
                    run = 0;
                end
            end
            req_w[0] = 1'b0;
            check("b2b_acks", acks, 3);
            check("b2b_dones", dones, 3);
            check("b2b_ack_with_done", both, 2);
            check("b2b_period", a1 - a0, 19);
            check("b2b_gaps", gaps, 2);
            check("b2b_gap_len_bad", gap_bad, 0);
            check("b2b_overlap", ovl, 0);
        end

        // Reset asserted mid-ACTIVE of a write.
        begin
            int got, done_seen, busy_seen;
            got = 0; done_seen = 0; busy_seen = 0;
            @(negedge CLK);
            WR = 1'b1; CS_SEL = 2'b10; ADDR = 3'd0; WDATA = 16'h5A5A;
            req_w[0] = 1'b1;
            for (int i = 0; i < 20 && got == 0; i++) begin
                @(negedge CLK);
                if (ack_w[0]) req_w[0] = 1'b0;
                if (!diow_w[0]) got = 1;
            end
            req_w[0] = 1'b0;
            check("mr_reached_active", got, 1);
            repeat (3) @(negedge CLK);
            check("mr_dd_before", dd0, 16'h5A5A);
            check("mr_diow_before", diow_w[0], 0);
            rst_n = 1'b0;
            park = 1'b1;
            #1;
            check("mr_diow", diow_w[0], 1);
            check("mr_dior", dior_w[0], 1);
            check("mr_cs", cs_w[0], 2'b11);
            check("mr_da", da_w[0], 3'd0);
            check("mr_dd_free", dd0, 16'h0000);
            check("mr_busy", busy_w[0], 0);
            @(negedge CLK);
            rst_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge CLK);
                if (done_w[0]) done_seen++;
                if (busy_w[0]) busy_seen++;
            end
            park = 1'b0;
            check("mr_no_done", done_seen, 0);
            check("mr_no_busy", busy_seen, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1);
    end

endmodule
